// File: rtl/vga_capture.sv
// vga_capture: VGA receiver that locks to 640x480 sync timing and writes a 2:1 decimated frame into a frame buffer
module vga_capture #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT_START = 144,
  parameter int V_ACT_START = 34,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic        clk25MHz,
  input  logic        reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_red,
  input  logic        i_green,
  input  logic        i_blue,
  output logic        o_wr_en,
  output logic [16:0] o_wr_addr,
  output logic [2:0]  o_wr_data,
  output logic        o_frame_done,
  output logic        o_locked,
  output logic        o_err
);
  localparam logic [9:0]  H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0]  H_OVER    = 10'(H_TOTAL);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_OVER    = 10'(V_TOTAL);
  localparam logic [9:0]  H_START   = 10'(H_ACT_START);
  localparam logic [9:0]  V_START   = 10'(V_ACT_START);
  localparam logic [9:0]  H_ACT     = 10'(H_ACTIVE);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [9:0]  CNT_MAX   = 10'h3ff;
  localparam logic [16:0] LAST_ADDR = 17'((H_ACTIVE / 2) * (V_ACTIVE / 2) - 1);

  typedef enum logic [1:0] {S_SEARCH, S_CHECK, S_LOCKED} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_bad, w_bad_nxt;
  logic [4:0]  r_s1, r_s2;
  logic [9:0]  r_h_cnt, r_v_cnt;
  logic        r_v_pend;
  logic [16:0] r_addr;
  logic        r_wr_en, r_done, r_err;
  logic [16:0] r_wr_addr;
  logic [2:0]  r_wr_data;

  logic        w_h_fall, w_v_fall, w_v_reset, w_viol, w_cap;
  logic [9:0]  w_hx, w_vy;

  // s1/s2 hold {hsync, vsync, red, green, blue}; sync edges are seen between the two stages
  assign w_h_fall  = r_s2[4] & ~r_s1[4];
  assign w_v_fall  = r_s2[3] & ~r_s1[3];
  assign w_v_reset = w_h_fall & (r_v_pend | w_v_fall);
  assign w_viol    = (w_h_fall && r_h_cnt != H_LAST) || r_h_cnt == H_OVER ||
                     (w_v_reset && r_v_cnt != V_LAST) || r_v_cnt == V_OVER;
  assign w_hx      = r_h_cnt - H_START;
  assign w_vy      = r_v_cnt - V_START;
  assign w_cap     = r_state == S_LOCKED && !w_viol && w_hx < H_ACT && w_vy < V_ACT && !w_hx[0] && !w_vy[0];

  assign o_wr_en      = r_wr_en;
  assign o_wr_addr    = r_wr_addr;
  assign o_wr_data    = r_wr_data;
  assign o_frame_done = r_done;
  assign o_err        = r_err;
  assign o_locked     = r_state == S_LOCKED;

  // input pipeline and position recovery from sync edges
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_h_cnt  <= '0;
      r_v_cnt  <= '0;
      r_v_pend <= 1'b0;
    end else begin
      r_s1     <= {i_hsync, i_vsync, i_red, i_green, i_blue};
      r_s2     <= r_s1;
      r_h_cnt  <= w_h_fall ? '0 : (r_h_cnt == CNT_MAX ? r_h_cnt : r_h_cnt + 10'd1);
      r_v_pend <= w_h_fall ? 1'b0 : (r_v_pend | w_v_fall);
      r_v_cnt  <= w_v_reset ? '0 : (w_h_fall && r_v_cnt != CNT_MAX) ? r_v_cnt + 10'd1 : r_v_cnt;
    end
  end

  // lock state register; the bad flag remembers a violation seen during a checking frame
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      r_state <= S_SEARCH;
      r_bad   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_bad   <= w_bad_nxt;
    end
  end

  // lock sequencing: one clean frame between two v_cnt resets is required before locking
  always_comb begin
    w_state_nxt = r_state;
    w_bad_nxt   = 1'b0;
    case (r_state)
      S_SEARCH: w_state_nxt = w_v_reset ? S_CHECK : S_SEARCH;
      S_CHECK: begin
        w_state_nxt = (w_v_reset && !(r_bad || w_viol)) ? S_LOCKED : S_CHECK;
        w_bad_nxt   = !w_v_reset && (r_bad || w_viol);
      end
      S_LOCKED: w_state_nxt = w_viol ? S_SEARCH : S_LOCKED;
      default:  w_state_nxt = S_SEARCH;
    endcase
  end

  // decimated frame-buffer writes, frame-done and error pulses
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      r_addr    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_addr    <= w_v_reset ? '0 : (w_cap ? r_addr + 17'd1 : r_addr);
      r_wr_en   <= w_cap;
      r_wr_addr <= w_cap ? r_addr : r_wr_addr;
      r_wr_data <= w_cap ? r_s2[2:0] : r_wr_data;
      r_done    <= r_wr_en && r_wr_addr == LAST_ADDR;
      r_err     <= r_state == S_LOCKED && w_viol;
    end
  end
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- VGA receiver: the receiving end of the 640x480@60 stream our display counter and pattern generator produce (1-bit R/G/B, active-low hsync/vsync, 25 MHz pixel clock).
- Recovers pixel position from the sync edges and checks the line and frame timing.
- Decimates the stream 2:1 in each axis and issues 320x240 write transactions into the frame buffer RAM.
- Writes are issued only after timing lock.

Parameters:
- H_TOTAL, 800, clocks per line
- V_TOTAL, 525, lines per frame
- H_ACT_START, 144, h_cnt of first active pixel (h_cnt = 0 is the hsync falling-edge cycle)
- V_ACT_START, 34, v_cnt of first active line
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame

Ports:
- clk25MHz  in  1  pixel clock
- reset  in  1  synchronous, active-high
- i_hsync  in  1  horizontal sync, active low
- i_vsync  in  1  vertical sync, active low
- i_red  in  1  red pixel bit
- i_green  in  1  green pixel bit
- i_blue  in  1  blue pixel bit
- o_wr_en  out  1  frame-buffer write strobe
- o_wr_addr  out  17  write address, 0..76799
- o_wr_data  out  3  {red, green, blue}
- o_frame_done  out  1  one-cycle pulse after the last write of a frame
- o_locked  out  1  high while in S_LOCKED
- o_err  out  1  one-cycle pulse on timing violation while locked

Behaviour:
- Clock and reset:
  - Single clock domain.
  - reset is synchronous, active-high, and wins over all other events.
  - All outputs reset to 0, state resets to S_SEARCH, counters and address reset to 0.
- Input pipeline:
  - All five inputs are registered into stage s1, then s2.
  - Sync falling edge = s1 low AND s2 high.
  - Colour is taken from s2, so it stays aligned with the counters.
  - Fixed latency: 3 clocks from a pixel at the pins to its o_wr_en/o_wr_data.
- h_cnt (10 bit):
  - Set to 0 on the hsync falling-edge cycle; otherwise increments.
  - Saturates at 1023.
- v_cnt (10 bit):
  - vsync falling edge sets a pending flag.
  - On the next hsync falling edge: if the flag is set, v_cnt goes to 0 and the flag clears; otherwise v_cnt increments, saturating at 1023.
- Line violation:
  - hsync edge arrives with previous h_cnt != H_TOTAL-1, or
  - h_cnt reaches H_TOTAL with no edge.
- Frame violation:
  - v_cnt reset occurs with previous v_cnt != V_TOTAL-1, or
  - v_cnt reaches V_TOTAL.
- S_SEARCH:
  - No checks, no writes.
  - First v_cnt reset (vsync-aligned hsync edge) -> S_CHECK.
- S_CHECK:
  - No writes.
  - Any violation -> S_CHECK restarts, counting from the next v_cnt reset; o_err is not pulsed.
  - Next v_cnt reset with no violation during the frame -> S_LOCKED.
- S_LOCKED:
  - o_locked = 1.
  - Any violation -> o_err pulse (1 cycle) and S_SEARCH in the same cycle.
  - o_locked drops the next cycle.
  - A write in flight in the violation cycle is suppressed.
- Capture window (S_LOCKED only):
  - hx = h_cnt - H_ACT_START, vy = v_cnt - V_ACT_START.
  - Capture when 0 <= hx < H_ACTIVE, 0 <= vy < V_ACTIVE, hx[0] = 0 and vy[0] = 0.
  - Registered write: o_wr_en = 1, o_wr_data = s2 colour, o_wr_addr = address counter.
- Address counter (17 bit):
  - Cleared at every v_cnt reset; incremented after each write.
  - No multiplier.
  - Never exceeds 76799; writes beyond it are impossible by the window definition.
- o_frame_done:
  - Pulses the cycle after the write to address 76799.
  - Exactly once per locked frame.
  - No pulse if lock is lost before that write.
- Simultaneous vsync and hsync falling edges in the same cycle: the pending flag is consumed by that same hsync edge.

Test Plan:
- Reset: assert reset 3 cycles mid-stream -> all outputs 0, o_locked 0; deassert -> state is S_SEARCH, no writes until relock.
- Ideal 800x525 stream from display counter + pattern generator:
  - o_locked rises at the 2nd v_cnt reset after reset.
  - Next frame has exactly 76800 writes with addresses 0..76799 in order.
  - o_frame_done fires once.
- Pattern check: colour = {x[5], y[5], x[6]} -> data at address (y/2)*320 + x/2 matches source pixel (x,y) for all writes.
- Latency: single red pixel at (0,0) -> o_wr_en at address 0 exactly 3 clocks after it appears at the pins; the odd pixel (1,0) produces no write.
- Short line (799 clocks) while locked -> o_err pulse 1 cycle, o_locked low next cycle, writes stop; relock after 2 further clean v_cnt resets.
- hsync held high for 2000 clocks while locked -> violation when h_cnt hits 800, o_err pulse, no write beyond that point, no o_frame_done for that frame.
